// File: rtl/eco32f_rf_write_sched_pkg.sv
// Shared types and constants for the ECO32F register-file write scheduler.
// Register-file geometry, LLU buffer entry layout and write-port source select.
package eco32f_rf_write_sched_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } llu_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_LLU  = 2'd2
    } wr_src_t;

    // r0 is hardwired, so it can never be the target of an outstanding LLU result.
    function automatic logic reg_pending(input logic [RF_NREGS-1:0] pend,
                                         input logic [RF_ADDR_W-1:0] addr);
        return (addr != '0) && pend[addr];
    endfunction

endpackage

// File: rtl/eco32f_sync_fifo.sv
// Small show-ahead FIFO: the head entry is visible combinationally while non-empty.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module eco32f_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage is not reset: emptiness is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/eco32f_rf_write_sched.sv
// Arbitrates the single RF write port between WB and buffered LLU results, and keeps
// the LLU pending scoreboard for ID stalls. Optional starve guard: ECO32F_RF_SCHED_STARVE_EN.
module eco32f_rf_write_sched
    import eco32f_rf_write_sched_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rf_x_addr,
    input  logic [4:0]  id_rf_y_addr,
    input  logic [4:0]  id_rf_r_addr,
    input  logic        id_rf_r_we,
    output logic        id_sb_stall,
    input  logic        ex_llu_issue,
    input  logic [4:0]  ex_llu_addr,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        llu_valid,
    input  logic [4:0]  llu_addr,
    input  logic [31:0] llu_data,
    output logic        llu_ready,
    input  logic [4:0]  wb_rf_r_addr,
    input  logic        wb_rf_r_we,
    input  logic [31:0] wb_rf_r,
    output logic        pipe_hold,
    output logic [4:0]  rf_waddr,
    output logic        rf_we,
    output logic [31:0] rf_wdata
);

    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
        $error("eco32f_rf_write_sched: BUF_DEPTH must be a power of 2 >= 2 and MAX_WAIT >= 1");
    end

    llu_entry_t          push_entry;
    llu_entry_t          head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                issue_set;
    wr_src_t             wr_src;
    logic [RF_NREGS-1:0] pending_reg;
    logic [RF_NREGS-1:0] pending_set;
    logic [RF_NREGS-1:0] pending_clr;

    // Results for r0 are acknowledged but never stored.
    assign llu_ready  = !fifo_full;
    assign push       = llu_valid && !fifo_full && (llu_addr != '0);
    assign push_entry = {llu_addr, llu_data};

    eco32f_sync_fifo #(
        .WIDTH($bits(llu_entry_t)),
        .DEPTH(BUF_DEPTH)
    ) u_llu_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign issue_set = ex_llu_issue && !ex_stall && !ex_flush && (ex_llu_addr != '0);

    for (genvar gi = 0; gi < RF_NREGS; gi++) begin : g_sb
        assign pending_set[gi] = issue_set && (ex_llu_addr == RF_ADDR_W'(gi));
        assign pending_clr[gi] = pop && (head_entry.addr == RF_ADDR_W'(gi));
    end

    // A new issue to a register whose older result retires this cycle keeps it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_reg <= '0;
        else        pending_reg <= (pending_reg & ~pending_clr) | pending_set;
    end

    assign id_sb_stall = reg_pending(pending_reg, id_rf_x_addr) |
                         reg_pending(pending_reg, id_rf_y_addr) |
                         (id_rf_r_we & reg_pending(pending_reg, id_rf_r_addr));

`ifdef ECO32F_RF_SCHED_STARVE_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_reg;

    assign pipe_hold = !fifo_empty && (wait_cnt_reg == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt_reg <= '0;
        else if (pop || fifo_empty)
            wait_cnt_reg <= '0;
        else if (wb_rf_r_we && wait_cnt_reg != WAIT_W'(MAX_WAIT))
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end

    a_no_wb_under_hold: assert property (@(posedge clk) disable iff (!rst_n)
                                         !(pipe_hold && wb_rf_r_we));
`else
    assign pipe_hold = 1'b0;
`endif

    // Held head always wins so a misbehaving WB cannot starve the buffer indefinitely.
    always_comb begin
        wr_src = SRC_NONE;
        if (rst_n) begin
            if (wb_rf_r_we && !pipe_hold) wr_src = SRC_WB;
            else if (!fifo_empty)         wr_src = SRC_LLU;
        end
    end

    assign pop = (wr_src == SRC_LLU);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (wr_src)
            SRC_WB: begin
                rf_we    = 1'b1;
                rf_waddr = wb_rf_r_addr;
                rf_wdata = wb_rf_r;
            end
            SRC_LLU: begin
                rf_we    = 1'b1;
                rf_waddr = head_entry.addr;
                rf_wdata = head_entry.data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eco32f_rf_write_sched.sv
// Self-checking bench for eco32f_rf_write_sched: directed vector table, reset and
// starve-guard sequences, then randomized traffic against a queue-based reference model.
module tb_eco32f_rf_write_sched;

    localparam int BUF_DEPTH = 2;
    localparam int MAX_WAIT  = 4;
`ifdef ECO32F_RF_SCHED_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rf_x_addr, id_rf_y_addr, id_rf_r_addr;
    logic        id_rf_r_we, id_sb_stall;
    logic        ex_llu_issue, ex_stall, ex_flush;
    logic [4:0]  ex_llu_addr;
    logic        llu_valid, llu_ready;
    logic [4:0]  llu_addr;
    logic [31:0] llu_data;
    logic [4:0]  wb_rf_r_addr;
    logic        wb_rf_r_we;
    logic [31:0] wb_rf_r;
    logic        pipe_hold;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eco32f_rf_write_sched #(.BUF_DEPTH(BUF_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rf_x_addr(id_rf_x_addr), .id_rf_y_addr(id_rf_y_addr),
        .id_rf_r_addr(id_rf_r_addr), .id_rf_r_we(id_rf_r_we), .id_sb_stall(id_sb_stall),
        .ex_llu_issue(ex_llu_issue), .ex_llu_addr(ex_llu_addr),
        .ex_stall(ex_stall), .ex_flush(ex_flush),
        .llu_valid(llu_valid), .llu_addr(llu_addr), .llu_data(llu_data), .llu_ready(llu_ready),
        .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r(wb_rf_r),
        .pipe_hold(pipe_hold), .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic [4:0]  x, y, r;
        logic        rwe, iss, exs, exf, lv, wbwe;
        logic [4:0]  ia, la, wba;
        logic [31:0] ld, wbd;
        logic        e_stall, e_ready, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t vecs[$];

    function automatic vec_t v(input int x, y, r, rwe, iss, ia, exs, exf, lv, la,
                               input logic [31:0] ld, input int wbwe, wba,
                               input logic [31:0] wbd, input int es, er, ewe, ewa,
                               input logic [31:0] ewd);
        vec_t t;
        t.x = 5'(x);  t.y = 5'(y);  t.r = 5'(r);  t.rwe = 1'(rwe);
        t.iss = 1'(iss); t.ia = 5'(ia); t.exs = 1'(exs); t.exf = 1'(exf);
        t.lv = 1'(lv); t.la = 5'(la); t.ld = ld;
        t.wbwe = 1'(wbwe); t.wba = 5'(wba); t.wbd = wbd;
        t.e_stall = 1'(es); t.e_ready = 1'(er); t.e_we = 1'(ewe);
        t.e_waddr = 5'(ewa); t.e_wdata = ewd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_inputs();
        id_rf_x_addr = '0; id_rf_y_addr = '0; id_rf_r_addr = '0; id_rf_r_we = 1'b0;
        ex_llu_issue = 1'b0; ex_llu_addr = '0; ex_stall = 1'b0; ex_flush = 1'b0;
        llu_valid = 1'b0; llu_addr = '0; llu_data = '0;
        wb_rf_r_we = 1'b0; wb_rf_r_addr = '0; wb_rf_r = '0;
    endtask

    task automatic drive(input vec_t t);
        id_rf_x_addr = t.x; id_rf_y_addr = t.y; id_rf_r_addr = t.r; id_rf_r_we = t.rwe;
        ex_llu_issue = t.iss; ex_llu_addr = t.ia; ex_stall = t.exs; ex_flush = t.exf;
        llu_valid = t.lv; llu_addr = t.la; llu_data = t.ld;
        wb_rf_r_we = t.wbwe; wb_rf_r_addr = t.wba; wb_rf_r = t.wbd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " stall"}, 64'(id_sb_stall), 64'd0);
        chk({tag, " ready"}, 64'(llu_ready), 64'd1);
        chk({tag, " hold"},  64'(pipe_hold), 64'd0);
        chk({tag, " we"},    64'(rf_we), 64'd0);
        chk({tag, " waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, " wdata"}, 64'(rf_wdata), 64'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        clr_inputs();
        #1;
        chk_reset_outputs("reset");
        do_reset();

        // ---------------- directed vector table ----------------
        //        x  y  r rwe iss ia exs exf lv la  ld          wbwe wba wbd          es er we wa wd
        vecs.push_back(v(5, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(5, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD,   0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 1, 5, 32'hDEAD));
        vecs.push_back(v(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        // LLU r7 while WB busy
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234,   1, 2, 32'hAAAA,     0, 1, 1, 2, 32'hAAAA));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 3, 32'hBBBB,     0, 1, 1, 3, 32'hBBBB));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 4, 32'hCCCC,     0, 1, 1, 4, 32'hCCCC));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 1, 7, 32'h1234));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        // re-issue r3 on the cycle its older result retires
        vecs.push_back(v(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33,     0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(0, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 1, 3, 32'h33));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 1, 3, 32'h44,     0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 1, 3, 32'h44));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        // flushed / stalled / r0 issues never mark pending
        vecs.push_back(v(0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(6, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(6, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        // destination check depends on id_rf_r_we
        vecs.push_back(v(0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 8, 1, 0, 0, 0, 0, 1, 8, 32'h88,     0, 0, 0,            1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            1, 1, 1, 8, 32'h88));
        vecs.push_back(v(0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        // r0 result is accepted and discarded
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h99,     0, 0, 0,            0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));
        // fill buffer with WB busy; third result held until a pop frees a slot
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'hA,     1, 1, 32'h11,       0, 1, 1, 1, 32'h11));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hB,     1, 1, 32'h12,       0, 1, 1, 1, 32'h12));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC,     1, 1, 32'h13,       0, 0, 1, 1, 32'h13));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC,     0, 0, 0,            0, 0, 1, 10, 32'hA));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC,     0, 0, 0,            0, 1, 1, 11, 32'hB));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 1, 12, 32'hC));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,            0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), 64'(id_sb_stall), 64'(vecs[i].e_stall));
            chk($sformatf("vec%0d ready", i), 64'(llu_ready),   64'(vecs[i].e_ready));
            chk($sformatf("vec%0d hold", i),  64'(pipe_hold),   64'd0);
            chk($sformatf("vec%0d we", i),    64'(rf_we),       64'(vecs[i].e_we));
            chk($sformatf("vec%0d waddr", i), 64'(rf_waddr),    64'(vecs[i].e_waddr));
            chk($sformatf("vec%0d wdata", i), 64'(rf_wdata),    64'(vecs[i].e_wdata));
            @(posedge clk);
        end

        // ---------------- reset with buffered results and pending r9 ----------------
        #1;
        clr_inputs();
        ex_llu_issue = 1'b1; ex_llu_addr = 5'd9;
        wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd1; wb_rf_r = 32'h5;
        llu_valid = 1'b1; llu_addr = 5'd20; llu_data = 32'h20;
        @(posedge clk); #1;
        ex_llu_issue = 1'b0; llu_addr = 5'd21; llu_data = 32'h21;
        @(posedge clk); #1;
        llu_valid = 1'b0; id_rf_x_addr = 5'd9;
        @(negedge clk);
        chk("prerst stall", 64'(id_sb_stall), 64'd1);
        chk("prerst ready", 64'(llu_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        wb_rf_r_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("postrst%0d we", k), 64'(rf_we), 64'd0);
            chk($sformatf("postrst%0d stall", k), 64'(id_sb_stall), 64'd0);
        end
        @(posedge clk);

`ifdef ECO32F_RF_SCHED_STARVE_EN
        // ---------------- starve guard with WB permanently busy ----------------
        do_reset();
        #1;
        wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd2; wb_rf_r = 32'hB0;
        llu_valid = 1'b1; llu_addr = 5'd13; llu_data = 32'h13;
        @(posedge clk); #1;
        llu_valid = 1'b0;
        for (int k = 0; k < MAX_WAIT; k++) begin
            @(negedge clk);
            chk($sformatf("starve%0d hold", k), 64'(pipe_hold), 64'd0);
            chk($sformatf("starve%0d waddr", k), 64'(rf_waddr), 64'd2);
            @(posedge clk); #1;
        end
        wb_rf_r_we = 1'b0;
        @(negedge clk);
        chk("starve hold", 64'(pipe_hold), 64'd1);
        chk("starve pop", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd13, 32'h13}));
        @(posedge clk); #1;
        wb_rf_r_we = 1'b1;
        @(negedge clk);
        chk("starve release", 64'(pipe_hold), 64'd0);
        chk("starve wb", 64'(rf_waddr), 64'd2);
        @(posedge clk);
`endif

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        begin
            bit   pend[32];
            ent_t q[$];
            int   waited;
            bit   lv_hold;
            logic exp_stall, exp_ready, exp_hold, exp_we;
            logic [4:0]  exp_waddr;
            logic [31:0] exp_wdata;
            bit   popped, accepted;
            waited = 0;
            lv_hold = 1'b0;
            foreach (pend[k]) pend[k] = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                #1;
                id_rf_x_addr = 5'($urandom_range(0, 7));
                id_rf_y_addr = 5'($urandom_range(0, 7));
                id_rf_r_addr = 5'($urandom_range(0, 7));
                id_rf_r_we   = 1'($urandom_range(0, 1));
                ex_llu_issue = ($urandom_range(0, 9) < 3);
                ex_llu_addr  = 5'($urandom_range(0, 7));
                ex_stall     = ($urandom_range(0, 9) < 2);
                ex_flush     = ($urandom_range(0, 9) < 2);
                if (!lv_hold) begin
                    llu_valid = ($urandom_range(0, 9) < 4);
                    llu_addr  = 5'($urandom_range(0, 7));
                    llu_data  = $urandom;
                end
                exp_hold = STARVE && (q.size() > 0) && (waited == MAX_WAIT);
                wb_rf_r_we   = ($urandom_range(0, 9) < 5) && !exp_hold;
                wb_rf_r_addr = 5'($urandom_range(0, 31));
                wb_rf_r      = $urandom;

                exp_ready = (q.size() < BUF_DEPTH);
                exp_stall = pend[id_rf_x_addr] | pend[id_rf_y_addr] |
                            (id_rf_r_we & pend[id_rf_r_addr]);
                popped = !wb_rf_r_we && (q.size() > 0);
                if (wb_rf_r_we) begin
                    exp_we = 1'b1; exp_waddr = wb_rf_r_addr; exp_wdata = wb_rf_r;
                end else if (popped) begin
                    exp_we = 1'b1; exp_waddr = q[0].a; exp_wdata = q[0].d;
                end else begin
                    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
                end

                @(negedge clk);
                chk($sformatf("rand%0d", c),
                    64'({id_sb_stall, llu_ready, pipe_hold, rf_we, rf_waddr, rf_wdata}),
                    64'({exp_stall, exp_ready, exp_hold, exp_we, exp_waddr, exp_wdata}));

                accepted = llu_valid && exp_ready;
                lv_hold  = llu_valid && !accepted;
                if (popped) begin
                    pend[q[0].a] = 1'b0;
                    void'(q.pop_front());
                    waited = 0;
                end else if (q.size() > 0 && waited < MAX_WAIT) begin
                    waited++;
                end
                if (ex_llu_issue && !ex_stall && !ex_flush && ex_llu_addr != 0)
                    pend[ex_llu_addr] = 1'b1;
                if (accepted && llu_addr != 0)
                    q.push_back('{a: llu_addr, d: llu_data});
                @(posedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
